// File: rtl/kd_stream_loader.sv
// kd_stream_loader: drains the serial input FIFO after a load_kdtree pulse and
// distributes the words into the internal-node, leaf and query memories.
// The stream is split into three back-to-back sections (nodes, leaves, queries).
// load_done is raised once the last query has been written.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for load_kdtree, FIFO untouched
// S_NODES   | (idx, median) word pairs -> node memory
// S_LEAVES  | 5 patch words + 1 patch index per slot -> leaf memory
// S_QUERIES | 5 patch words per query -> query memory
// S_DONE    | load complete, load_done high, FIFO untouched
module kd_stream_loader #(
   parameter int DATA_WIDTH   = 11,
   parameter int PATCH_SIZE   = 5,
   parameter int LEAF_SIZE    = 8,
   parameter int NUM_LEAVES   = 64,
   parameter int NUM_QUERYS   = 494,
   parameter int LEAF_ADDR_W  = $clog2(NUM_LEAVES*LEAF_SIZE),
   parameter int NODE_ADDR_W  = $clog2(NUM_LEAVES),
   parameter int QUERY_ADDR_W = $clog2(NUM_QUERYS)
) (
   input  logic                             wb_clk_i,
   input  logic                             wb_rst_i,
   input  logic                             load_kdtree,
   input  logic [DATA_WIDTH-1:0]            in_fifo_rdata,
   input  logic                             in_fifo_rempty_n,
   output logic                             in_fifo_deq,
   output logic                             node_wen,
   output logic [NODE_ADDR_W-1:0]           node_addr,
   output logic [DATA_WIDTH-1:0]            node_idx,
   output logic [DATA_WIDTH-1:0]            node_median,
   output logic                             leaf_wen,
   output logic [LEAF_ADDR_W-1:0]           leaf_addr,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wdata,
   output logic [DATA_WIDTH-1:0]            leaf_pidx,
   output logic                             query_wen,
   output logic [QUERY_ADDR_W-1:0]          query_addr,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wdata,
   output logic                             busy,
   output logic                             load_done
);

   localparam int NUM_NODES   = NUM_LEAVES - 1;
   localparam int NUM_PATCHES = NUM_LEAVES * LEAF_SIZE;
   localparam int PATCH_W     = PATCH_SIZE * DATA_WIDTH;
   localparam int SUB_W       = $clog2(PATCH_SIZE + 1);
   // One item counter is shared by all sections, so it must fit the widest address.
   localparam int CNT_W       = (LEAF_ADDR_W > QUERY_ADDR_W) ? LEAF_ADDR_W : QUERY_ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NODES,
      S_LEAVES,
      S_QUERIES,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [SUB_W-1:0]   sub;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_WIDTH-1:0] idx_lat;
   logic [PATCH_W-1:0] patch_sr;
   logic [PATCH_W-1:0] patch_shift;
   logic               item_end;
   logic               seq_end;

   assign busy        = (state == S_NODES) || (state == S_LEAVES) || (state == S_QUERIES);
   assign in_fifo_deq = in_fifo_rempty_n & busy;

   // New words enter at the top so that word 0 ends up in the LSBs after a full patch.
   assign patch_shift = {in_fifo_rdata, patch_sr[PATCH_W-1:DATA_WIDTH]};

   // Flag the last word of the current item and of the whole section.
   always_comb begin
      item_end = 1'b0;
      seq_end  = 1'b0;
      case (state)
         S_NODES: begin
            item_end = (sub == SUB_W'(1));
            seq_end  = item_end && (cnt == CNT_W'(NUM_NODES - 1));
         end
         S_LEAVES: begin
            item_end = (sub == SUB_W'(PATCH_SIZE));
            seq_end  = item_end && (cnt == CNT_W'(NUM_PATCHES - 1));
         end
         S_QUERIES: begin
            item_end = (sub == SUB_W'(PATCH_SIZE - 1));
            seq_end  = item_end && (cnt == CNT_W'(NUM_QUERYS - 1));
         end
         default: begin
            item_end = 1'b0;
            seq_end  = 1'b0;
         end
      endcase
   end

   // Next state: a start pulse always wins, otherwise advance at section end.
   always_comb begin
      state_next = state;
      if (load_kdtree) begin
         state_next = S_NODES;
      end else if (in_fifo_deq && seq_end) begin
         case (state)
            S_NODES:   state_next = S_LEAVES;
            S_LEAVES:  state_next = S_QUERIES;
            S_QUERIES: state_next = S_DONE;
            default:   state_next = state;
         endcase
      end
   end

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Counters, assembly registers and the registered memory write ports.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sub         <= '0;
         cnt         <= '0;
         idx_lat     <= '0;
         patch_sr    <= '0;
         node_wen    <= 1'b0;
         node_addr   <= '0;
         node_idx    <= '0;
         node_median <= '0;
         leaf_wen    <= 1'b0;
         leaf_addr   <= '0;
         leaf_wdata  <= '0;
         leaf_pidx   <= '0;
         query_wen   <= 1'b0;
         query_addr  <= '0;
         query_wdata <= '0;
         load_done   <= 1'b0;
      end else begin
         node_wen  <= 1'b0;
         leaf_wen  <= 1'b0;
         query_wen <= 1'b0;
         // Rises one cycle after entering DONE, i.e. after the final query strobe.
         load_done <= (state == S_DONE) && !load_kdtree;
         if (load_kdtree) begin
            // Restart drops any partial item; a word popped on this edge is node word 0.
            sub <= '0;
            cnt <= '0;
            if (in_fifo_deq) begin
               idx_lat <= in_fifo_rdata;
               sub     <= SUB_W'(1);
            end
         end else if (in_fifo_deq) begin
            sub <= item_end ? '0 : sub + SUB_W'(1);
            if (item_end) begin
               cnt <= seq_end ? '0 : cnt + CNT_W'(1);
            end
            case (state)
               S_NODES: begin
                  if (!item_end) begin
                     idx_lat <= in_fifo_rdata;
                  end else begin
                     node_wen    <= 1'b1;
                     node_addr   <= cnt[NODE_ADDR_W-1:0];
                     node_idx    <= idx_lat;
                     node_median <= in_fifo_rdata;
                  end
               end
               S_LEAVES: begin
                  if (!item_end) begin
                     patch_sr <= patch_shift;
                  end else begin
                     leaf_wen   <= 1'b1;
                     leaf_addr  <= cnt[LEAF_ADDR_W-1:0];
                     leaf_wdata <= patch_sr;
                     leaf_pidx  <= in_fifo_rdata;
                  end
               end
               S_QUERIES: begin
                  if (!item_end) begin
                     patch_sr <= patch_shift;
                  end else begin
                     query_wen   <= 1'b1;
                     query_addr  <= cnt[QUERY_ADDR_W-1:0];
                     query_wdata <= patch_shift;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kd_stream_loader.sv
// Bench for kd_stream_loader: random word streams fed from a FIFO model,
// expected memory contents derived from the stream layout.
module tb_kd_stream_loader;
   localparam int DW         = 11;
   localparam int PS         = 5;
   localparam int LS         = 8;
   localparam int NL         = 64;
   localparam int NN         = NL - 1;
   localparam int NQ         = 494;
   localparam int NP         = NL * LS;
   localparam int NODE_WORDS = 2 * NN;
   localparam int LEAF_WORDS = NP * (PS + 1);
   localparam int Q_BASE     = NODE_WORDS + LEAF_WORDS;
   localparam int LOAD_WORDS = Q_BASE + NQ * PS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load = 1'b0;
   logic [DW-1:0] rdata;
   logic rempty_n;
   logic deq;
   logic node_wen, leaf_wen, query_wen, busy, load_done;
   logic [5:0] node_addr;
   logic [DW-1:0] node_idx, node_median, leaf_pidx;
   logic [8:0] leaf_addr, query_addr;
   logic [PS*DW-1:0] leaf_wdata, query_wdata;

   kd_stream_loader dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .load_kdtree(load),
      .in_fifo_rdata(rdata), .in_fifo_rempty_n(rempty_n), .in_fifo_deq(deq),
      .node_wen(node_wen), .node_addr(node_addr), .node_idx(node_idx), .node_median(node_median),
      .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_wdata(leaf_wdata), .leaf_pidx(leaf_pidx),
      .query_wen(query_wen), .query_addr(query_addr), .query_wdata(query_wdata),
      .busy(busy), .load_done(load_done)
   );

   always #5 clk = ~clk;

   // FIFO model: an array of words with read/write pointers.
   logic [DW-1:0] stream [0:65535];
   int wr_cnt = 0;
   int rd_ptr = 0;
   logic gap = 1'b0;
   logic flush = 1'b0;

   always @(posedge clk) begin
      if (flush) rd_ptr <= wr_cnt;
      else if (deq) rd_ptr <= rd_ptr + 1;
   end
   assign rempty_n = (rd_ptr < wr_cnt) && !gap;
   assign rdata    = stream[rd_ptr[15:0]];

   // Capture of all memory writes.
   int node_addr_q[$], node_idx_q[$], node_med_q[$];
   int leaf_addr_q[$], leaf_pidx_q[$];
   logic [PS*DW-1:0] leaf_data_q[$];
   int q_addr_q[$];
   logic [PS*DW-1:0] q_data_q[$];
   int cyc = 0, multi = 0, last_q_cyc = -1, ld_rise_cyc = -1;
   logic ld_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (node_wen) begin
         node_addr_q.push_back(int'(node_addr));
         node_idx_q.push_back(int'(node_idx));
         node_med_q.push_back(int'(node_median));
      end
      if (leaf_wen) begin
         leaf_addr_q.push_back(int'(leaf_addr));
         leaf_pidx_q.push_back(int'(leaf_pidx));
         leaf_data_q.push_back(leaf_wdata);
      end
      if (query_wen) begin
         q_addr_q.push_back(int'(query_addr));
         q_data_q.push_back(query_wdata);
         last_q_cyc = cyc;
      end
      if ((int'(node_wen) + int'(leaf_wen) + int'(query_wen)) > 1) multi = multi + 1;
      if (load_done && !ld_prev) ld_rise_cyc = cyc;
      ld_prev = load_done;
   end

   int n_cmp = 0;
   int n_fail = 0;

   function automatic logic [DW-1:0] sw(input int i);
      return stream[i[15:0]];
   endfunction

   function automatic logic [PS*DW-1:0] patch_at(input int pos);
      logic [PS*DW-1:0] v;
      v = '0;
      for (int k = 0; k < PS; k++) v[k*DW +: DW] = sw(pos + k);
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_caps();
      node_addr_q.delete(); node_idx_q.delete(); node_med_q.delete();
      leaf_addr_q.delete(); leaf_pidx_q.delete(); leaf_data_q.delete();
      q_addr_q.delete(); q_data_q.delete();
      multi = 0; last_q_cyc = -1; ld_rise_cyc = -1;
   endtask

   task automatic push_load(output int base);
      base = wr_cnt;
      for (int i = 0; i < LOAD_WORDS; i++) begin
         stream[wr_cnt[15:0]] = DW'($urandom_range(0, 2047));
         wr_cnt = wr_cnt + 1;
      end
   endtask

   task automatic pulse_load();
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n;
      n = 0;
      while (!load_done && n < budget) begin
         tick();
         n++;
      end
      ok = load_done;
   endtask

   task automatic wait_ptr(input int target, input int budget);
      int n;
      n = 0;
      while (rd_ptr < target && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int p0;
      for (int i = 0; i < 4; i++) begin
         stream[wr_cnt[15:0]] = DW'(i + 1);
         wr_cnt = wr_cnt + 1;
      end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({deq, node_wen, leaf_wen, query_wen, busy, load_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl c%0d: got deq/nw/lw/qw/busy/done=%b, want 000000", c,
                     {deq, node_wen, leaf_wen, query_wen, busy, load_done});
         end
         n_cmp++;
         if ({node_addr, node_idx, node_median, leaf_addr, leaf_wdata, leaf_pidx, query_addr, query_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data c%0d: outputs not zero", c);
         end
      end
      rst = 1'b0;
      p0 = rd_ptr;
      tick();
      tick();
      n_cmp++;
      if (deq !== 1'b0 || rd_ptr != p0) begin
         n_fail++;
         $display("FAIL idle_nopop: got deq=%b popped=%0d, want deq=0 popped=0", deq, rd_ptr - p0);
      end
      do_flush();
   endtask

   task automatic test_full_load();
      int base, p0;
      bit ok;
      clear_caps();
      push_load(base);
      stream[(base + 10) & 16'hFFFF] = DW'(4);
      stream[(base + 11) & 16'hFFFF] = DW'(1023);
      for (int k = 0; k < PS; k++) stream[(base + NODE_WORDS + 26*6 + k) & 16'hFFFF] = DW'(10*(k+1));
      stream[(base + NODE_WORDS + 26*6 + 5) & 16'hFFFF] = DW'(777);
      pulse_load();
      wait_done(8000, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL full_done: got load_done=%b, want 1", load_done); end
      n_cmp++;
      if (node_addr_q.size() != NN || leaf_addr_q.size() != NP || q_addr_q.size() != NQ) begin
         n_fail++;
         $display("FAIL full_counts: got %0d/%0d/%0d, want %0d/%0d/%0d",
                  node_addr_q.size(), leaf_addr_q.size(), q_addr_q.size(), NN, NP, NQ);
      end
      for (int n = 0; n < NN && n < node_addr_q.size(); n++) begin
         n_cmp++;
         if (node_addr_q[n] != n || node_idx_q[n] != int'(sw(base + 2*n)) || node_med_q[n] != int'(sw(base + 2*n + 1))) begin
            n_fail++;
            $display("FAIL full_node%0d: got %0d/%0d/%0d, want %0d/%0d/%0d", n, node_addr_q[n],
                     node_idx_q[n], node_med_q[n], n, sw(base + 2*n), sw(base + 2*n + 1));
         end
      end
      for (int p = 0; p < NP && p < leaf_addr_q.size(); p++) begin
         n_cmp++;
         if (leaf_addr_q[p] != p || leaf_data_q[p] !== patch_at(base + NODE_WORDS + 6*p) ||
             leaf_pidx_q[p] != int'(sw(base + NODE_WORDS + 6*p + 5))) begin
            n_fail++;
            $display("FAIL full_leaf%0d: got %0d/%h/%0d, want %0d/%h/%0d", p, leaf_addr_q[p], leaf_data_q[p],
                     leaf_pidx_q[p], p, patch_at(base + NODE_WORDS + 6*p), sw(base + NODE_WORDS + 6*p + 5));
         end
      end
      for (int q = 0; q < NQ && q < q_addr_q.size(); q++) begin
         n_cmp++;
         if (q_addr_q[q] != q || q_data_q[q] !== patch_at(base + Q_BASE + 5*q)) begin
            n_fail++;
            $display("FAIL full_query%0d: got %0d/%h, want %0d/%h", q, q_addr_q[q], q_data_q[q],
                     q, patch_at(base + Q_BASE + 5*q));
         end
      end
      n_cmp++;
      if (node_addr_q.size() == 0 || leaf_addr_q.size() == 0 || q_addr_q.size() == 0 ||
          node_addr_q[$] != NN-1 || leaf_addr_q[$] != NP-1 || q_addr_q[$] != NQ-1) begin
         n_fail++;
         $display("FAIL full_last_addr: got last addresses wrong or missing, want %0d/%0d/%0d", NN-1, NP-1, NQ-1);
      end
      n_cmp++;
      if (ld_rise_cyc != last_q_cyc + 1) begin
         n_fail++;
         $display("FAIL done_timing: got rise cyc %0d, want %0d", ld_rise_cyc, last_q_cyc + 1);
      end
      n_cmp++;
      if (multi != 0) begin n_fail++; $display("FAIL one_strobe: got %0d overlaps, want 0", multi); end
      n_cmp++;
      if (rd_ptr != wr_cnt) begin
         n_fail++;
         $display("FAIL full_consumed: got %0d words popped, want %0d", rd_ptr - base, LOAD_WORDS);
      end
      for (int i = 0; i < 3; i++) begin
         stream[wr_cnt[15:0]] = DW'($urandom_range(0, 2047));
         wr_cnt = wr_cnt + 1;
      end
      p0 = rd_ptr;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if (rd_ptr != p0 || deq !== 1'b0 || load_done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_nopop: got popped=%0d deq=%b done=%b, want 0/0/1", rd_ptr - p0, deq, load_done);
      end
      do_flush();
   endtask

   task automatic test_packing();
      logic [PS*DW-1:0] want;
      for (int k = 0; k < PS; k++) want[k*DW +: DW] = DW'(10*(k+1));
      n_cmp++;
      if (leaf_addr_q.size() <= 26 || leaf_addr_q[26] != 26 || leaf_data_q[26] !== want || leaf_pidx_q[26] != 777) begin
         n_fail++;
         $display("FAIL pack_leaf: got entry 26 wrong or missing, want addr=26 data=%h pidx=777", want);
      end
      n_cmp++;
      if (node_addr_q.size() <= 5 || node_addr_q[5] != 5 || node_idx_q[5] != 4 || node_med_q[5] != 1023) begin
         n_fail++;
         $display("FAIL pack_node: got entry 5 wrong or missing, want addr=5 idx=4 median=1023");
      end
   endtask

   task automatic test_starvation();
      int base, target, q, off;
      bit ok;
      clear_caps();
      push_load(base);
      pulse_load();
      for (int g = 0; g < 7; g++) begin
         q = g*70 + int'($urandom_range(0, 60));
         off = int'($urandom_range(1, 4));
         target = base + Q_BASE + 5*q + off;
         wait_ptr(target, 8000);
         n_cmp++;
         if (rd_ptr != target) begin
            n_fail++;
            $display("FAIL starve_reach%0d: got ptr %0d, want %0d", g, rd_ptr, target);
         end
         gap = 1'b1;
         #1;
         n_cmp++;
         if (deq !== 1'b0) begin n_fail++; $display("FAIL starve_deq%0d: got deq=%b, want 0", g, deq); end
         tick();
         gap = 1'b0;
      end
      wait_done(8000, ok);
      n_cmp++;
      if (!ok || q_addr_q.size() != NQ) begin
         n_fail++;
         $display("FAIL starve_count: got done=%b queries=%0d, want 1/%0d", load_done, q_addr_q.size(), NQ);
      end
      for (int i = 0; i < NQ && i < q_addr_q.size(); i++) begin
         n_cmp++;
         if (q_addr_q[i] != i || q_data_q[i] !== patch_at(base + Q_BASE + 5*i)) begin
            n_fail++;
            $display("FAIL starve_query%0d: got %0d/%h, want %0d/%h", i, q_addr_q[i], q_data_q[i],
                     i, patch_at(base + Q_BASE + 5*i));
         end
      end
   endtask

   task automatic test_restart();
      int base, base2;
      bit ok;
      clear_caps();
      do_flush();
      base = wr_cnt;
      for (int i = 0; i < NODE_WORDS + 6*4 + 2; i++) begin
         stream[wr_cnt[15:0]] = DW'($urandom_range(0, 2047));
         wr_cnt = wr_cnt + 1;
      end
      push_load(base2);
      pulse_load();
      n_cmp++;
      if (load_done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_from_done: got done=%b busy=%b, want 0/1", load_done, busy);
      end
      wait_ptr(base2, 2000);
      n_cmp++;
      if (rd_ptr != base2 || leaf_addr_q.size() != 4) begin
         n_fail++;
         $display("FAIL restart_pre: got ptr=%0d leaves=%0d, want %0d/4", rd_ptr, leaf_addr_q.size(), base2);
      end
      clear_caps();
      pulse_load();
      n_cmp++;
      if (busy !== 1'b1 || rd_ptr != base2 + 1) begin
         n_fail++;
         $display("FAIL restart_pulse: got busy=%b popped=%0d, want 1/1", busy, rd_ptr - base2);
      end
      wait_done(8000, ok);
      n_cmp++;
      if (!ok || node_addr_q.size() != NN || leaf_addr_q.size() != NP || q_addr_q.size() != NQ) begin
         n_fail++;
         $display("FAIL restart_counts: got done=%b %0d/%0d/%0d, want 1 %0d/%0d/%0d", load_done,
                  node_addr_q.size(), leaf_addr_q.size(), q_addr_q.size(), NN, NP, NQ);
      end
      for (int n = 0; n < NN && n < node_addr_q.size(); n++) begin
         n_cmp++;
         if (node_addr_q[n] != n || node_idx_q[n] != int'(sw(base2 + 2*n)) || node_med_q[n] != int'(sw(base2 + 2*n + 1))) begin
            n_fail++;
            $display("FAIL restart_node%0d: got %0d/%0d/%0d, want %0d/%0d/%0d", n, node_addr_q[n],
                     node_idx_q[n], node_med_q[n], n, sw(base2 + 2*n), sw(base2 + 2*n + 1));
         end
      end
      for (int p = 0; p < NP && p < leaf_addr_q.size(); p += 37) begin
         n_cmp++;
         if (leaf_addr_q[p] != p || leaf_data_q[p] !== patch_at(base2 + NODE_WORDS + 6*p)) begin
            n_fail++;
            $display("FAIL restart_leaf%0d: got %0d/%h, want %0d/%h", p, leaf_addr_q[p], leaf_data_q[p],
                     p, patch_at(base2 + NODE_WORDS + 6*p));
         end
      end
   endtask

   task automatic test_reset_mid();
      int base, target, qc;
      bit ok;
      clear_caps();
      push_load(base);
      pulse_load();
      target = base + Q_BASE + 5*100 + 4;
      wait_ptr(target, 8000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (query_wen !== 1'b0 || busy !== 1'b0 || deq !== 1'b0 || load_done !== 1'b0 || q_addr_q.size() != 100) begin
         n_fail++;
         $display("FAIL reset_mid: got qw=%b busy=%b deq=%b done=%b queries=%0d, want 0/0/0/0/100",
                  query_wen, busy, deq, load_done, q_addr_q.size());
      end
      qc = q_addr_q.size();
      tick();
      tick();
      n_cmp++;
      if (q_addr_q.size() != qc || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: got queries=%0d busy=%b, want %0d/0", q_addr_q.size(), busy, qc);
      end
      do_flush();
      clear_caps();
      push_load(base);
      pulse_load();
      wait_done(8000, ok);
      n_cmp++;
      if (!ok || node_addr_q.size() != NN || leaf_addr_q.size() != NP || q_addr_q.size() != NQ || multi != 0) begin
         n_fail++;
         $display("FAIL reload_counts: got done=%b %0d/%0d/%0d overlaps=%0d, want 1 %0d/%0d/%0d 0", load_done,
                  node_addr_q.size(), leaf_addr_q.size(), q_addr_q.size(), multi, NN, NP, NQ);
      end
      for (int q = 0; q < NQ && q < q_addr_q.size(); q += 13) begin
         n_cmp++;
         if (q_addr_q[q] != q || q_data_q[q] !== patch_at(base + Q_BASE + 5*q)) begin
            n_fail++;
            $display("FAIL reload_query%0d: got %0d/%h, want %0d/%h", q, q_addr_q[q], q_data_q[q],
                     q, patch_at(base + Q_BASE + 5*q));
         end
      end
      n_cmp++;
      if (ld_rise_cyc != last_q_cyc + 1) begin
         n_fail++;
         $display("FAIL reload_timing: got rise cyc %0d, want %0d", ld_rise_cyc, last_q_cyc + 1);
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_packing();
      test_starvation();
      test_restart();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/kd_stream_loader.md
Name: kd_stream_loader

Overview:
- Upstream stage of the ANN core: drains the 11-bit input FIFO and routes the serial word stream into the internal-node, leaf and query memories.
- Stream order: internal nodes (index, median per node), then leaves (5 data words + 1 patch index per patch, LEAF_SIZE patches per leaf), then query patches (5 words each).
- Started by a load_kdtree pulse; asserts load_done once the last query is written, so the main FSM can be started.

Parameters:
- DATA_WIDTH, 11, bits per stream word
- PATCH_SIZE, 5, words per patch
- LEAF_SIZE, 8, patches per leaf
- NUM_LEAVES, 64, leaves; NUM_NODES = NUM_LEAVES-1
- NUM_QUERYS, 494, query patches
- LEAF_ADDR_W, $clog2(NUM_LEAVES*LEAF_SIZE) = 9
- NODE_ADDR_W, $clog2(NUM_LEAVES) = 6
- QUERY_ADDR_W, $clog2(NUM_QUERYS) = 9

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- load_kdtree  in  1  single-cycle start pulse
- in_fifo_rdata  in  DATA_WIDTH  FIFO head word (first-word-fall-through)
- in_fifo_rempty_n  in  1  FIFO not empty
- in_fifo_deq  out  1  pop head word this cycle
- node_wen  out  1  internal-node write strobe
- node_addr  out  NODE_ADDR_W  node number
- node_idx  out  DATA_WIDTH  split dimension
- node_median  out  DATA_WIDTH  split value
- leaf_wen  out  1  leaf-patch write strobe
- leaf_addr  out  LEAF_ADDR_W  leaf*LEAF_SIZE + slot
- leaf_wdata  out  PATCH_SIZE*DATA_WIDTH  patch, word0 in LSBs
- leaf_pidx  out  DATA_WIDTH  original-image patch index
- query_wen  out  1  query write strobe
- query_addr  out  QUERY_ADDR_W  query number
- query_wdata  out  PATCH_SIZE*DATA_WIDTH  query patch, word0 in LSBs
- busy  out  1  high in NODES/LEAVES/QUERIES
- load_done  out  1  level, high in DONE

Behaviour:
- States: IDLE, NODES, LEAVES, QUERIES, DONE.
  - IDLE/DONE --load_kdtree--> NODES.
  - NODES -> LEAVES after word 2*NUM_NODES-1 is consumed.
  - LEAVES -> QUERIES after word NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1)-1 is consumed.
  - QUERIES -> DONE after word NUM_QUERYS*PATCH_SIZE-1 is consumed.
- Reset: state IDLE, all counters and shift registers 0, all outputs 0.
- in_fifo_deq = in_fifo_rempty_n & busy (combinational). A word is consumed iff in_fifo_deq=1 on a clock edge. Never pop while empty; FIFO gaps simply stall the counters.
- Word counter (sub), plus patch/node counter per state. Counters are cleared on every state transition.
- NODES:
  - Even word is latched as idx.
  - Odd word causes node_wen=1 on the next cycle, with node_idx=latched idx, node_median=word, node_addr=node count.
- LEAVES:
  - Words 0..4 of each 6-word group shift into the patch register.
  - Word 5 causes leaf_wen=1 on the next cycle, with leaf_pidx=word 5 and leaf_addr=patch count (0..511).
- QUERIES: the 5th word of each patch causes query_wen=1 on the next cycle, with query_addr=query count (0..493).
- Write strobes:
  - Registered, exactly 1 cycle wide; at most one strobe per cycle.
  - Address and data outputs are held stable until the next strobe.
- Latency: the final word of an item is consumed on edge N; the strobe is high during cycle N+1.
- load_kdtree while busy: restart NODES at count 0 on the next edge; discard the partial patch/node; suppress any strobe that the same edge would have produced.
- load_kdtree and a word consumed on the same edge: the pulse wins, and that word counts as node word 0 of the new load.
- load_kdtree in DONE: load_done drops on the next edge.
- wb_rst_i mid-load: return to IDLE on the next edge; pending strobes are cancelled.
- Words arriving after DONE are not popped; they remain in the FIFO.
- Address counters never wrap in normal operation; the terminal count forces the state transition.

Test Plan:
- Reset behaviour: hold wb_rst_i 3 cycles with FIFO non-empty -> in_fifo_deq=0, all strobes 0, busy=0, load_done=0.
- Full load, back-to-back stream: pulse load_kdtree, then 126 node words, 3072 leaf words and 2470 query words, FIFO never empty.
  - Required: 63 node_wen, 512 leaf_wen and 494 query_wen pulses.
  - Required: last addresses 62/511/493.
  - Required: load_done rises the cycle after the final query_wen.
- Packing check:
  - Leaf 3 slot 2, words 10,20,30,40,50 with pidx 777 -> leaf_addr=26, leaf_wdata word0=10 … word4=50, leaf_pidx=777.
  - Node 5 words (4, 1023) -> node_addr=5, node_idx=4, node_median=1023.
- FIFO starvation: deassert in_fifo_rempty_n for 7 random cycles inside a query patch -> in_fifo_deq=0 during gaps; exactly one query_wen per 5 consumed words; data identical to the gap-free run.
- Restart mid-load: pulse load_kdtree after 2 words of a leaf patch -> no leaf_wen for the partial patch, state NODES, next node_wen has node_addr=0.
- Reset mid-load: assert wb_rst_i during QUERIES at query 100 -> IDLE next edge, no strobe; a subsequent full load completes normally.
